// File: rtl/icache_dm_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the geometry parameters, the address field positions, the refill FSM
// state encoding and small helpers that split a fetch address into
// offset / index / tag.
package icache_dm_pkg;

  localparam int C_LINES_X = 4;               // log2 number of lines
  localparam int C_WORDS_X = 2;               // log2 words per line
  localparam int C_XLEN    = 32;              // address / data width

  localparam int C_LINES   = 1 << C_LINES_X;
  localparam int C_WORDS   = 1 << C_WORDS_X;

  // Address layout: [tag | index | offset | 2'b byte]
  localparam int C_OFF_LSB = 2;
  localparam int C_IDX_LSB = C_WORDS_X + 2;
  localparam int C_TAG_LSB = C_WORDS_X + C_LINES_X + 2;
  localparam int C_TAG_W   = C_XLEN - C_TAG_LSB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  function automatic logic [C_WORDS_X-1:0] addr_off(input logic [C_XLEN-1:0] a);
    return a[C_IDX_LSB-1:C_OFF_LSB];
  endfunction

  function automatic logic [C_LINES_X-1:0] addr_idx(input logic [C_XLEN-1:0] a);
    return a[C_TAG_LSB-1:C_IDX_LSB];
  endfunction

  function automatic logic [C_TAG_W-1:0] addr_tag(input logic [C_XLEN-1:0] a);
    return a[C_XLEN-1:C_TAG_LSB];
  endfunction

endpackage

// File: rtl/icache_tagram.sv
// Valid bits and tag array of the direct-mapped instruction cache.
// Ports:
//   clk, resetb  - clock, asynchronous active-low reset (clears valid bits)
//   flush        - clear every valid bit this cycle (wins over a write)
//   lookup_idx   - line index for the combinational lookup
//   lookup_tag   - tag compared against the stored tag
//   hit          - line valid and tag matches
//   wr_en        - write the tag and set the valid bit of wr_idx
//   wr_idx       - line index to write
//   wr_tag       - tag to store
module icache_tagram
  import icache_dm_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 flush,
  input  logic [C_LINES_X-1:0] lookup_idx,
  input  logic [C_TAG_W-1:0]   lookup_tag,
  output logic                 hit,
  input  logic                 wr_en,
  input  logic [C_LINES_X-1:0] wr_idx,
  input  logic [C_TAG_W-1:0]   wr_tag
);

  logic [C_LINES-1:0] valid_q;
  logic [C_TAG_W-1:0] tag_q [C_LINES];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag storage is not reset; the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache between the prefetch unit and
// the instruction memory bus.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends on ready of the same channel.
// Ports:
//   clk, resetb             - clock, asynchronous active-low reset
//   flush_i                 - invalidate all lines (fence.i)
//   ireqvalid_i/ireqready_o - fetch request handshake, ireqaddr_i address
//   irspvalid_o/irspready_i - fetch response handshake, irspdata_o word,
//                             irsprerr_o bus error on the line
//   mreqvalid_o/mreqready_i - memory read request, mreqaddr_o word address
//   mrspvalid_i             - memory read beat (in order), mrspdata_i data,
//                             mrsperr_i error on that beat
// Hits answer one cycle after acceptance. A miss refills the whole line with
// single-word reads, then answers from the freshly written data array.
module icache_dm
  import icache_dm_pkg::*;
(
  input  logic              clk,
  input  logic              resetb,
  input  logic              flush_i,
  input  logic              ireqvalid_i,
  output logic              ireqready_o,
  input  logic [C_XLEN-1:0] ireqaddr_i,
  output logic              irspvalid_o,
  input  logic              irspready_i,
  output logic              irsprerr_o,
  output logic [C_XLEN-1:0] irspdata_o,
  output logic              mreqvalid_o,
  input  logic              mreqready_i,
  output logic [C_XLEN-1:0] mreqaddr_o,
  input  logic              mrspvalid_i,
  input  logic              mrsperr_i,
  input  logic [C_XLEN-1:0] mrspdata_i
);

  state_t state_q, state_d;

  logic buf_free;
  logic accept;
  logic hit;
  logic start_miss;
  logic fill_load;
  logic tag_wr;
  logic req_issue;
  logic last_beat;

  // req_cnt carries one extra bit: its MSB marks "all requests issued".
  logic [C_WORDS_X:0]   req_cnt_q;
  logic [C_WORDS_X-1:0] rsp_cnt_q;
  logic [C_WORDS_X-1:0] miss_off_q;
  logic [C_LINES_X-1:0] miss_idx_q;
  logic [C_TAG_W-1:0]   miss_tag_q;
  logic                 line_err_q;
  logic                 flushed_q;

  logic [C_XLEN-1:0] data_q [C_LINES*C_WORDS];

  logic [C_LINES_X+C_WORDS_X-1:0] hit_word;
  logic [C_LINES_X+C_WORDS_X-1:0] miss_word;
  logic [C_LINES_X+C_WORDS_X-1:0] fill_word;

  // Byte-offset bits of the fetch address carry no information.
  logic unused_byte_bits;
  assign unused_byte_bits = ^ireqaddr_i[1:0];

  assign hit_word  = {addr_idx(ireqaddr_i), addr_off(ireqaddr_i)};
  assign miss_word = {miss_idx_q, miss_off_q};
  assign fill_word = {miss_idx_q, rsp_cnt_q};

  // ---------------------------------------------------------------- front side
  assign buf_free    = ~irspvalid_o | irspready_i;
  assign ireqready_o = resetb & (state_q == ST_IDLE) & buf_free & ~flush_i;
  assign accept      = ireqvalid_i & ireqready_o;

  icache_tagram u_tagram (
    .clk        (clk),
    .resetb     (resetb),
    .flush      (flush_i),
    .lookup_idx (addr_idx(ireqaddr_i)),
    .lookup_tag (addr_tag(ireqaddr_i)),
    .hit        (hit),
    .wr_en      (tag_wr),
    .wr_idx     (miss_idx_q),
    .wr_tag     (miss_tag_q)
  );

  // ---------------------------------------------------------------- memory side
  assign mreqvalid_o = (state_q == ST_REFILL) & ~req_cnt_q[C_WORDS_X];
  assign mreqaddr_o  = (state_q == ST_REFILL)
                     ? {miss_tag_q, miss_idx_q, req_cnt_q[C_WORDS_X-1:0], 2'b00}
                     : '0;
  assign req_issue   = mreqvalid_o & mreqready_i;
  assign last_beat   = mrspvalid_i & (&rsp_cnt_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    start_miss = 1'b0;
    fill_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && !hit) begin
          start_miss = 1'b1;
          state_d    = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (last_beat) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (buf_free) begin
          fill_load = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A line is only validated when every beat was clean and no flush hit it
  // at any point between the miss and this write.
  assign tag_wr = fill_load & ~line_err_q & ~flushed_q & ~flush_i;

  // ---------------------------------------------------------------- refill control
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      miss_off_q <= '0;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      line_err_q <= 1'b0;
      flushed_q  <= 1'b0;
    end else if (start_miss) begin
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      miss_off_q <= addr_off(ireqaddr_i);
      miss_idx_q <= addr_idx(ireqaddr_i);
      miss_tag_q <= addr_tag(ireqaddr_i);
      line_err_q <= 1'b0;
      flushed_q  <= 1'b0;
    end else if (state_q == ST_REFILL) begin
      if (req_issue) begin
        req_cnt_q <= req_cnt_q + 1'b1;
      end
      if (mrspvalid_i) begin
        rsp_cnt_q <= rsp_cnt_q + 1'b1;
      end
      line_err_q <= line_err_q | (mrspvalid_i & mrsperr_i);
      flushed_q  <= flushed_q | flush_i;
    end
  end

  // Data array is not reset.
  always_ff @(posedge clk) begin
    if ((state_q == ST_REFILL) && mrspvalid_i) begin
      data_q[fill_word] <= mrspdata_i;
    end
  end

  // ---------------------------------------------------------------- response buffer
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      irspvalid_o <= 1'b0;
      irsprerr_o  <= 1'b0;
      irspdata_o  <= '0;
    end else if (accept && hit) begin
      irspvalid_o <= 1'b1;
      irsprerr_o  <= 1'b0;
      irspdata_o  <= data_q[hit_word];
    end else if (fill_load) begin
      irspvalid_o <= 1'b1;
      irsprerr_o  <= line_err_q;
      irspdata_o  <= data_q[miss_word];
    end else if (irspready_i) begin
      irspvalid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm. The memory model answers each accepted read
// one cycle later with data equal to the word address.
module tb_icache_dm;

  logic        clk;
  logic        resetb;
  logic        flush_i;
  logic        ireqvalid_i;
  logic        ireqready_o;
  logic [31:0] ireqaddr_i;
  logic        irspvalid_o;
  logic        irspready_i;
  logic        irsprerr_o;
  logic [31:0] irspdata_o;
  logic        mreqvalid_o;
  logic        mreqready_i;
  logic [31:0] mreqaddr_o;
  logic        mrspvalid_i;
  logic        mrsperr_i;
  logic [31:0] mrspdata_i;

  int total = 0;
  int bad   = 0;

  logic [31:0] req_log[$];
  logic [31:0] exp_q[$];
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          mem_rand = 1'b0;

  icache_dm dut (
    .clk         (clk),
    .resetb      (resetb),
    .flush_i     (flush_i),
    .ireqvalid_i (ireqvalid_i),
    .ireqready_o (ireqready_o),
    .ireqaddr_i  (ireqaddr_i),
    .irspvalid_o (irspvalid_o),
    .irspready_i (irspready_i),
    .irsprerr_o  (irsprerr_o),
    .irspdata_o  (irspdata_o),
    .mreqvalid_o (mreqvalid_o),
    .mreqready_i (mreqready_i),
    .mreqaddr_o  (mreqaddr_o),
    .mrspvalid_i (mrspvalid_i),
    .mrsperr_i   (mrsperr_i),
    .mrspdata_i  (mrspdata_i)
  );

  // ------------------------------------------------------------ clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ memory model
  initial begin
    logic        have_pend;
    logic [31:0] pend_addr;
    have_pend   = 1'b0;
    pend_addr   = '0;
    mrspvalid_i = 1'b0;
    mrsperr_i   = 1'b0;
    mrspdata_i  = '0;
    mreqready_i = 1'b1;
    forever begin
      @(negedge clk);
      if (have_pend) begin
        mrspvalid_i = 1'b1;
        mrspdata_i  = pend_addr;
        mrsperr_i   = (pend_addr == err_addr);
      end else begin
        mrspvalid_i = 1'b0;
        mrsperr_i   = 1'b0;
      end
      mreqready_i = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      have_pend = mreqvalid_o & mreqready_i;
      pend_addr = mreqaddr_o;
      if (have_pend) req_log.push_back(mreqaddr_o);
    end
  end

  // ------------------------------------------------------------ driver
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_reqs,
                          input int exp_lat, input string name);
    int base;
    int waited;
    int lat;
    bit acc;
    bit got;
    base = req_log.size();
    @(negedge clk);
    ireqvalid_i = 1'b1;
    ireqaddr_i  = addr;
    irspready_i = 1'b1;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 50) begin
      #2;
      if (ireqready_o) acc = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL %s accept: ireqready never rose for addr %h", name, addr);
    end
    @(negedge clk);
    ireqvalid_i = 1'b0;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 100) begin
      #2;
      if (irspvalid_o) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s response: no irspvalid within %0d cycles", name, lat);
    end
    total++;
    if (irspdata_o !== exp_data) begin
      bad++;
      $display("FAIL %s data: got %h want %h", name, irspdata_o, exp_data);
    end
    total++;
    if (irsprerr_o !== exp_err) begin
      bad++;
      $display("FAIL %s rerr: got %b want %b", name, irsprerr_o, exp_err);
    end
    if (exp_lat > 0) begin
      total++;
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
    end
    total++;
    if (req_log.size() - base != exp_reqs) begin
      bad++;
      $display("FAIL %s memreads: got %0d want %0d", name, req_log.size() - base, exp_reqs);
    end else begin
      for (int k = 0; k < exp_reqs; k++) begin
        total++;
        if (req_log[base+k] !== ({addr[31:4], 4'h0} + 32'(4 * k))) begin
          bad++;
          $display("FAIL %s memaddr%0d: got %h want %h", name, k, req_log[base+k],
                   {addr[31:4], 4'h0} + 32'(4 * k));
        end
      end
    end
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    resetb      = 1'b0;
    flush_i     = 1'b0;
    ireqvalid_i = 1'b1;
    ireqaddr_i  = 32'h100;
    irspready_i = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    total++; if (ireqready_o !== 1'b0) begin bad++; $display("FAIL reset ireqready: got %b want 0", ireqready_o); end
    total++; if (irspvalid_o !== 1'b0) begin bad++; $display("FAIL reset irspvalid: got %b want 0", irspvalid_o); end
    total++; if (irsprerr_o !== 1'b0) begin bad++; $display("FAIL reset irsprerr: got %b want 0", irsprerr_o); end
    total++; if (irspdata_o !== 32'h0) begin bad++; $display("FAIL reset irspdata: got %h want 0", irspdata_o); end
    total++; if (mreqvalid_o !== 1'b0) begin bad++; $display("FAIL reset mreqvalid: got %b want 0", mreqvalid_o); end
    total++; if (mreqaddr_o !== 32'h0) begin bad++; $display("FAIL reset mreqaddr: got %h want 0", mreqaddr_o); end
    ireqvalid_i = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    #2;
    total++; if (ireqready_o !== 1'b1) begin bad++; $display("FAIL post-reset ireqready: got %b want 1", ireqready_o); end
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h100, 32'h100, 1'b0, 4, 7, "cold_miss");
  endtask

  task automatic test_back_to_back();
    int base;
    base = req_log.size();
    @(negedge clk);
    irspready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ireqvalid_i = 1'b1;
      ireqaddr_i  = 32'h104 + 32'(4 * i);
      #2;
      total++;
      if (ireqready_o !== 1'b1) begin
        bad++;
        $display("FAIL b2b ready%0d: got %b want 1", i, ireqready_o);
      end
      if (i > 0) begin
        total++;
        if ({irspvalid_o, irspdata_o} !== {1'b1, 32'h104 + 32'(4 * (i - 1))}) begin
          bad++;
          $display("FAIL b2b rsp%0d: got v=%b d=%h want v=1 d=%h", i - 1, irspvalid_o,
                   irspdata_o, 32'h104 + 32'(4 * (i - 1)));
        end
      end
      @(negedge clk);
    end
    ireqvalid_i = 1'b0;
    #2;
    total++;
    if ({irspvalid_o, irspdata_o} !== {1'b1, 32'h10C}) begin
      bad++;
      $display("FAIL b2b rsp2: got v=%b d=%h want v=1 d=0000010c", irspvalid_o, irspdata_o);
    end
    total++;
    if (req_log.size() != base) begin
      bad++;
      $display("FAIL b2b memreads: got %0d want 0", req_log.size() - base);
    end
  endtask

  task automatic test_conflict();
    do_fetch(32'h500, 32'h500, 1'b0, 4, 7, "conflict_500");
    do_fetch(32'h100, 32'h100, 1'b0, 4, 7, "conflict_100");
  endtask

  task automatic test_error();
    err_addr = 32'h208;
    do_fetch(32'h200, 32'h200, 1'b1, 4, 7, "err_fill");
    err_addr = 32'hFFFF_FFFF;
    do_fetch(32'h200, 32'h200, 1'b0, 4, 7, "err_refetch");
    do_fetch(32'h200, 32'h200, 1'b0, 0, 1, "err_hit");
  endtask

  task automatic test_flush();
    fork
      do_fetch(32'h300, 32'h300, 1'b0, 4, 7, "flush_refill");
      begin
        repeat (3) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
      end
    join
    do_fetch(32'h300, 32'h300, 1'b0, 4, 7, "flush_refetch");
    do_fetch(32'h100, 32'h100, 1'b0, 4, 7, "flush_warm");
    do_fetch(32'h100, 32'h100, 1'b0, 0, 1, "flush_warm_hit");
    @(negedge clk);
    ireqvalid_i = 1'b1;
    ireqaddr_i  = 32'h100;
    flush_i     = 1'b1;
    #2;
    total++;
    if (ireqready_o !== 1'b0) begin
      bad++;
      $display("FAIL flush_with_req ready: got %b want 0", ireqready_o);
    end
    @(negedge clk);
    flush_i     = 1'b0;
    ireqvalid_i = 1'b0;
    do_fetch(32'h100, 32'h100, 1'b0, 4, 7, "flush_cold");
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    irspready_i = 1'b0;
    ireqvalid_i = 1'b1;
    ireqaddr_i  = 32'h100;
    #2;
    total++;
    if (ireqready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp first ready: got %b want 1", ireqready_o);
    end
    @(negedge clk);
    ireqaddr_i = 32'h104;
    for (int k = 0; k < 5; k++) begin
      #2;
      total++;
      if ({irspvalid_o, irspdata_o} !== {1'b1, 32'h100}) begin
        bad++;
        $display("FAIL bp hold%0d: got v=%b d=%h want v=1 d=00000100", k, irspvalid_o, irspdata_o);
      end
      total++;
      if (ireqready_o !== 1'b0) begin
        bad++;
        $display("FAIL bp ready%0d: got %b want 0", k, ireqready_o);
      end
      @(negedge clk);
    end
    irspready_i = 1'b1;
    #2;
    total++;
    if (ireqready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp release ready: got %b want 1", ireqready_o);
    end
    @(negedge clk);
    ireqvalid_i = 1'b0;
    #2;
    total++;
    if ({irspvalid_o, irspdata_o} !== {1'b1, 32'h104}) begin
      bad++;
      $display("FAIL bp next rsp: got v=%b d=%h want v=1 d=00000104", irspvalid_o, irspdata_o);
    end
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    irspready_i = 1'b1;
    ireqvalid_i = 1'b1;
    ireqaddr_i  = 32'h600;
    @(negedge clk);
    ireqvalid_i = 1'b0;
    @(negedge clk);
    resetb = 1'b0;
    #2;
    total++;
    if (mreqvalid_o !== 1'b0) begin
      bad++;
      $display("FAIL midreset mreqvalid: got %b want 0", mreqvalid_o);
    end
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    #2;
    total++;
    if (ireqready_o !== 1'b1) begin
      bad++;
      $display("FAIL midreset ready: got %b want 1", ireqready_o);
    end
    do_fetch(32'h100, 32'h100, 1'b0, 4, 7, "midreset_cold");
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    int n_req;
    int rcv;
    pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h500;
    pool[3] = 32'h204; pool[4] = 32'h30C; pool[5] = 32'h108;
    n_req = 40;
    rcv   = 0;
    exp_q.delete();
    mem_rand = 1'b1;
    fork
      begin
        @(negedge clk);
        for (int n = 0; n < n_req; n++) begin
          int waited;
          bit acc;
          ireqvalid_i = 1'b1;
          ireqaddr_i  = pool[$urandom_range(0, 5)];
          acc = 1'b0;
          waited = 0;
          while (!acc && waited < 200) begin
            #2;
            if (ireqready_o) acc = 1'b1;
            else begin
              @(negedge clk);
              waited++;
            end
          end
          if (!acc) begin
            total++;
            bad++;
            $display("FAIL rand accept: request %0d never accepted", n);
            break;
          end
          exp_q.push_back(ireqaddr_i);
          @(negedge clk);
          ireqvalid_i = 1'b0;
          if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        ireqvalid_i = 1'b0;
      end
      begin
        int cyc;
        logic [31:0] exp;
        cyc = 0;
        while (rcv < n_req && cyc < 4000) begin
          @(negedge clk);
          irspready_i = 1'($urandom_range(0, 1));
          #1;
          if (irspvalid_o && irspready_i) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++;
              $display("FAIL rand unexpected: got d=%h with nothing outstanding", irspdata_o);
            end else begin
              exp = exp_q.pop_front();
              if ({irsprerr_o, irspdata_o} !== {1'b0, exp}) begin
                bad++;
                $display("FAIL rand rsp%0d: got e=%b d=%h want e=0 d=%h", rcv, irsprerr_o, irspdata_o, exp);
              end
            end
            rcv++;
          end
          cyc++;
        end
      end
    join
    total++;
    if (rcv != n_req) begin
      bad++;
      $display("FAIL rand count: got %0d want %0d", rcv, n_req);
    end
    irspready_i = 1'b1;
    mem_rand = 1'b0;
  endtask

  // ------------------------------------------------------------ sequence + report
  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_error();
    test_flush();
    test_backpressure();
    test_reset_mid_refill();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
